// File: rtl/mem_bus_decoder_if.sv
// rtl/mem_bus_decoder_if.sv - core-side and slave-side signals of the memory bus decoder
interface mem_bus_decoder_if #(
  parameter int N_SLAVES = 3,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32
);
  logic                         m_req;
  logic                         m_we;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic                         m_ready;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_err;
  logic [N_SLAVES-1:0]          s_sel;
  logic                         s_we;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [N_SLAVES*DATA_W-1:0]   s_rdata;
  logic [N_SLAVES-1:0]          s_ready;

  // Environment view: the core drives requests, the slaves drive read data and completion.
  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    input  m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    output m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - routes one master to N address regions with wait states, timeout and error response
module mem_bus_decoder #(
  parameter int                        N_SLAVES  = 3,
  parameter int                        ADDR_W    = 12,
  parameter int                        DATA_W    = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE     = {12'h700, 12'h200, 12'h000},
  parameter logic [N_SLAVES*5-1:0]     SIZE_LOG2 = {5'd5, 5'd8, 5'd9},
  parameter int                        TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_decoder_if.slave bus,
  output logic [7:0]       err_count
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                hit;
  logic [IW-1:0]       hit_idx;
  logic [ADDR_W-1:0]   hit_off;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic [N_SLAVES-1:0] s_sel;
  logic                m_ready;
  logic                m_err;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr >= BASE[i*ADDR_W +: ADDR_W]) &&
          (64'(bus.m_addr - BASE[i*ADDR_W +: ADDR_W]) < (64'd1 << SIZE_LOG2[i*5 +: 5]))) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
        hit_off = bus.m_addr - BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    s_sel     = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ready = bus.s_ready[i];
        sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
        s_sel[i]  = (state_q == ACCESS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          if (hit) begin
            idx_d   = hit_idx;
            off_d   = hit_off;
            we_d    = bus.m_we;
            wdata_d = bus.m_wdata;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_ready     = (state_q == RESP) || (state_q == ERR);
  assign m_err       = (state_q == ERR) || ((state_q == RESP) && err_q);
  assign err_count_d = (m_ready && m_err && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.s_sel   = s_sel;
  assign bus.s_we    = (state_q == ACCESS) && we_q;
  assign bus.s_addr  = off_q;
  assign bus.s_wdata = wdata_q;
  assign bus.m_ready = m_ready;
  assign bus.m_err   = m_err;
  assign bus.m_rdata = (state_q == RESP) ? rdata_q : '0;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - directed self-checking bench for mem_bus_decoder
module tb_mem_bus_decoder;
  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  mem_bus_decoder_if #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_decoder #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .BASE({12'h700, 12'h200, 12'h000}),
    .SIZE_LOG2({5'd5, 5'd8, 5'd9}),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err_count(err_count)
  );

  int region_base[N] = '{'h000, 'h200, 'h700};
  int region_log2[N] = '{9, 8, 5};

  typedef struct {
    logic [N-1:0]  sel;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic rst_prev = 1'b1;
  int   m_errcnt = 0;

  int            acc_cnt, commit_cnt, first_cyc, resp_cyc, n_rdy, req_cyc;
  logic [N-1:0]  first_sel;
  logic          first_we;
  logic [AW-1:0] first_addr;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_prev) begin
        chk("rst_s_sel", bus.s_sel, 0);
        chk("rst_s_we", bus.s_we, 0);
        chk("rst_s_addr", bus.s_addr, 0);
        chk("rst_s_wdata", bus.s_wdata, 0);
        chk("rst_m_ready", bus.m_ready, 0);
        chk("rst_m_err", bus.m_err, 0);
        chk("rst_m_rdata", bus.m_rdata, 0);
        chk("rst_err_count", err_count, 0);
        m_errcnt = 0;
      end else begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{default: '0};
        chk("s_sel", bus.s_sel, e.sel);
        chk("s_we", bus.s_we, e.we);
        chk("m_ready", bus.m_ready, e.ready);
        chk("m_err", bus.m_err, e.err);
        chk("err_count", err_count, m_errcnt);
        if (e.sel != 0) begin
          chk("s_addr", bus.s_addr, e.addr);
          chk("s_wdata", bus.s_wdata, e.wdata);
        end
        if (e.ready) chk("m_rdata", bus.m_rdata, e.rdata);
        if (e.ready && e.err && m_errcnt < 255) m_errcnt++;
      end
      if (bus.s_sel != 0) begin
        if (acc_cnt == 0) begin
          first_cyc  = cyc;
          first_sel  = bus.s_sel;
          first_we   = bus.s_we;
          first_addr = bus.s_addr;
        end
        acc_cnt++;
        if (bus.s_we && ((bus.s_sel & bus.s_ready) != 0)) commit_cnt++;
      end
      if (bus.m_ready) begin
        n_rdy++;
        resp_cyc   = cyc;
        resp_rdata = bus.m_rdata;
        resp_err   = bus.m_err;
      end
    end
  end

  // Issue one request from IDLE; waits < 0 means the selected slave never answers.
  // abort_at >= 0 returns during that ACCESS cycle with the request still pending.
  task automatic txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                     input logic [DW-1:0] rdv, input int waits, input int abort_at);
    int   idx;
    int   n_acc;
    logic timed_out;
    exp_t e;
    idx = -1;
    for (int i = N - 1; i >= 0; i--)
      if (int'(addr) >= region_base[i] && int'(addr) < region_base[i] + (1 << region_log2[i])) idx = i;
    acc_cnt    = 0;
    commit_cnt = 0;
    req_cyc    = cyc;
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.s_ready = '1;
    bus.s_rdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    if (idx >= 0) begin
      bus.s_ready[idx] = 1'b0;
      bus.s_rdata[idx*DW +: DW] = rdv;
    end
    e = '{default: '0};
    exp_q.push_back(e);
    if (idx < 0) begin
      e.ready = 1'b1;
      e.err   = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end else begin
      timed_out = (waits < 0) || (waits >= TO);
      n_acc     = timed_out ? TO : waits + 1;
      e.sel     = N'(1 << idx);
      e.we      = we;
      e.addr    = AW'(int'(addr) - region_base[idx]);
      e.wdata   = wdata;
      repeat (n_acc) exp_q.push_back(e);
      e = '{default: '0};
      e.ready = 1'b1;
      e.err   = timed_out;
      e.rdata = (timed_out || we) ? '0 : rdv;
      exp_q.push_back(e);
      for (int j = 0; j < n_acc; j++) begin
        @(posedge clk); #1;
        if (abort_at == j) return;
        bus.s_ready[idx] = (j == waits);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    bus.m_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int r0;
    int start;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ready = '0;
    bus.s_rdata = '0;
    n_rdy       = 0;
    acc_cnt     = 0;
    commit_cnt  = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("init_err_count", err_count, 0);

    txn(12'h204, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, -1);
    chk("rd_sel", first_sel, 3'b010);
    chk("rd_addr", first_addr, 12'h004);
    chk("rd_sel_cycle", first_cyc - req_cyc, 1);
    chk("rd_latency", resp_cyc - req_cyc, 2);
    chk("rd_data", resp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", resp_err, 0);

    txn(12'h708, 1'b1, 32'hA5A5_0001, 32'hFFFF_FFFF, 3, -1);
    chk("wr_sel", first_sel, 3'b100);
    chk("wr_we", first_we, 1);
    chk("wr_addr", first_addr, 12'h008);
    chk("wr_sel_cycles", acc_cnt, 4);
    chk("wr_latency", resp_cyc - req_cyc, 5);
    chk("wr_rdata", resp_rdata, 0);
    chk("wr_commits", commit_cnt, 1);

    txn(12'h400, 1'b0, 32'h0, 32'h0, 0, -1);
    chk("unmap_sel_cycles", acc_cnt, 0);
    chk("unmap_latency", resp_cyc - req_cyc, 1);
    chk("unmap_err", resp_err, 1);
    chk("unmap_rdata", resp_rdata, 0);
    chk("unmap_err_count", err_count, 1);

    txn(12'h1FF, 1'b0, 32'h0, 32'h0123_4567, 1, -1);
    chk("top0_sel", first_sel, 3'b001);
    chk("top0_addr", first_addr, 12'h1FF);
    chk("top0_data", resp_rdata, 32'h0123_4567);
    txn(12'h300, 1'b0, 32'h0, 32'h0, 0, -1);
    chk("past1_err", resp_err, 1);
    txn(12'h71F, 1'b0, 32'h0, 32'h7777_0000, TO - 1, -1);
    chk("late_ready_err", resp_err, 0);
    chk("late_ready_sel_cycles", acc_cnt, 15);
    chk("late_ready_latency", resp_cyc - req_cyc, 16);
    chk("late_ready_data", resp_rdata, 32'h7777_0000);
    txn(12'h720, 1'b0, 32'h0, 32'h0, 0, -1);
    chk("past2_err", resp_err, 1);
    txn(12'h010, 1'b0, 32'h0, 32'h5555_5555, -1, -1);
    chk("to_sel_cycles", acc_cnt, 15);
    chk("to_latency", resp_cyc - req_cyc, 16);
    chk("to_err", resp_err, 1);
    chk("to_rdata", resp_rdata, 0);
    chk("err_count_4", err_count, 4);

    r0    = n_rdy;
    start = cyc;
    txn(12'h000, 1'b0, 32'h0, 32'h1234_5678, 0, -1);
    chk("b2b_rd_data", resp_rdata, 32'h1234_5678);
    txn(12'h210, 1'b1, 32'h0BAD_F00D, 32'h0, 0, -1);
    chk("b2b_wr_sel", first_sel, 3'b010);
    chk("b2b_wr_addr", first_addr, 12'h010);
    chk("b2b_last_resp", resp_cyc - start, 5);
    chk("b2b_ready_count", n_rdy - r0, 2);

    txn(12'h708, 1'b1, 32'hCAFE_F00D, 32'h0, -1, 3);
    rst         = 1'b1;
    bus.m_req   = 1'b0;
    bus.s_ready = '1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("rst_next_sel", bus.s_sel, 0);
    chk("rst_next_ready", bus.m_ready, 0);
    chk("rst_next_err_count", err_count, 0);
    @(posedge clk); #1;
    rst        = 1'b0;
    acc_cnt    = 0;
    commit_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_sel_after", acc_cnt, 0);
    chk("rst_no_commit_after", commit_cnt, 0);

    repeat (300) txn(12'h000, 1'b0, 32'h0, 32'h0, -1, -1);
    chk("err_count_saturated", err_count, 255);
    @(posedge clk); #1;
    chk("err_count_held", err_count, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
